// File: rtl/rv32i_uart_pkg.sv
// Shared encodings and helpers for the rv32i UART with FIFOs.
package rv32i_uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned MIN_BAUD_DIV = 3;

  typedef enum logic [2:0] {
    TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
  } rx_state_e;

  // Frame data-bit count (5 + cfg), never more than the configured maximum.
  function automatic logic [3:0] eff_nbits(input logic [1:0] cfg, input int unsigned max_bits);
    logic [3:0] n;
    n = 4'd5 + {2'b00, cfg};
    if (32'(n) > max_bits) n = 4'(max_bits);
    return n;
  endfunction

  // Encoding 11 is reserved and behaves as no parity.
  function automatic logic [1:0] norm_parity(input logic [1:0] cfg);
    return (cfg == PAR_EVEN || cfg == PAR_ODD) ? cfg : PAR_NONE;
  endfunction

endpackage

// File: rtl/rv32i_uart_sync_fifo.sv
// Synchronous show-ahead FIFO; a push on full is taken only alongside a pop.
module rv32i_uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Empty reads as zero so the head never exposes stale storage.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/rv32i_uart_fifo.sv
// UART with programmable divisor/format, TX and RX FIFOs and sticky error flags.
module rv32i_uart_fifo
  import rv32i_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    cfg_nbits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          tx_idle,
  output logic                          err_frame,
  output logic                          err_parity,
  output logic                          err_overrun,
  input  logic                          err_clr
);

  function automatic logic data_parity(input logic [DATA_BITS-1:0] d, input logic [3:0] n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i < int'(n)) p ^= d[i];
    end
    return p;
  endfunction

  logic [DIV_W-1:0] cfg_div;
  logic [3:0]       cfg_nb;
  logic [1:0]       cfg_par;

  assign cfg_div = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? DIV_W'(MIN_BAUD_DIV) : baud_div;
  assign cfg_nb  = eff_nbits(cfg_nbits, DATA_BITS);
  assign cfg_par = norm_parity(cfg_parity);

  // ---------------- TX ----------------
  logic                 tx_empty, tx_full, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]           tx_nbits_q, tx_nbits_d, tx_bit_q, tx_bit_d;
  logic                 tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
  logic                 tx_stop2_q, tx_stop2_d, tx_line_q, tx_line_d;
  logic                 tx_expire, tx_next_frame;

  rv32i_uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_div_d      = tx_div_q;
    tx_shift_d    = tx_shift_q;
    tx_nbits_d    = tx_nbits_q;
    tx_bit_d      = tx_bit_q;
    tx_par_en_d   = tx_par_en_q;
    tx_par_bit_d  = tx_par_bit_q;
    tx_stop2_d    = tx_stop2_q;
    tx_pop        = 1'b0;
    tx_next_frame = 1'b0;
    tx_expire     = (tx_cnt_q == '0);
    if (tx_state_q != TxIdle) tx_cnt_d = tx_cnt_q - 1'b1;

    unique case (tx_state_q)
      TxIdle: tx_next_frame = 1'b1;
      TxStart: if (tx_expire) begin
        tx_state_d = TxData;
        tx_cnt_d   = tx_div_q;
      end
      TxData: if (tx_expire) begin
        tx_cnt_d = tx_div_q;
        if (tx_bit_q == tx_nbits_q - 4'd1) begin
          tx_state_d = tx_par_en_q ? TxParity : TxStop1;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      TxParity: if (tx_expire) begin
        tx_state_d = TxStop1;
        tx_cnt_d   = tx_div_q;
      end
      TxStop1: if (tx_expire) begin
        tx_cnt_d = tx_div_q;
        if (tx_stop2_q) begin
          tx_state_d = TxStop2;
        end else begin
          tx_state_d    = TxIdle;
          tx_next_frame = 1'b1;
        end
      end
      TxStop2: if (tx_expire) begin
        tx_state_d    = TxIdle;
        tx_next_frame = 1'b1;
      end
      default: tx_state_d = TxIdle;
    endcase

    // Launching straight from the last stop bit keeps frames back-to-back.
    if (tx_next_frame && !tx_empty) begin
      tx_pop       = 1'b1;
      tx_state_d   = TxStart;
      tx_cnt_d     = cfg_div;
      tx_div_d     = cfg_div;
      tx_shift_d   = tx_head;
      tx_bit_d     = 4'd0;
      tx_nbits_d   = cfg_nb;
      tx_par_en_d  = (cfg_par != PAR_NONE);
      tx_par_bit_d = data_parity(tx_head, cfg_nb) ^ (cfg_par == PAR_ODD);
      tx_stop2_d   = cfg_stop2;
    end

    unique case (tx_state_d)
      TxStart:  tx_line_d = 1'b0;
      TxData:   tx_line_d = tx_shift_d[0];
      TxParity: tx_line_d = tx_par_bit_d;
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q   <= TxIdle;
      tx_cnt_q     <= '0;
      tx_div_q     <= '0;
      tx_shift_q   <= '0;
      tx_nbits_q   <= '0;
      tx_bit_q     <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_stop2_q   <= 1'b0;
      tx_line_q    <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_div_q     <= tx_div_d;
      tx_shift_q   <= tx_shift_d;
      tx_nbits_q   <= tx_nbits_d;
      tx_bit_q     <= tx_bit_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_par_bit_q <= tx_par_bit_d;
      tx_stop2_q   <= tx_stop2_d;
      tx_line_q    <= tx_line_d;
    end
  end

  assign uart_tx  = tx_line_q;
  assign tx_ready = ~tx_full;
  assign tx_idle  = tx_empty & (tx_state_q == TxIdle);

  // ---------------- RX ----------------
  logic                 rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  logic                 rx_full, rx_empty, rx_push;
  rx_state_e            rx_state_q, rx_state_d;
  logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [3:0]           rx_nbits_q, rx_nbits_d, rx_bit_q, rx_bit_d;
  logic [1:0]           rx_par_q, rx_par_d;
  logic                 rx_expire, set_frame, set_parity, set_overrun;
  logic                 err_frame_q, err_parity_q, err_overrun_q;

  rv32i_uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .din   (rx_shift_q),
    .pop   (rx_ready),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign rx_fall = rx_s3_q & ~rx_s2_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_shift_d  = rx_shift_q;
    rx_nbits_d  = rx_nbits_q;
    rx_bit_d    = rx_bit_q;
    rx_par_d    = rx_par_q;
    rx_push     = 1'b0;
    set_frame   = 1'b0;
    set_parity  = 1'b0;
    set_overrun = 1'b0;
    rx_expire   = (rx_cnt_q == '0);
    if (rx_state_q != RxIdle && rx_state_q != RxWaitHigh) rx_cnt_d = rx_cnt_q - 1'b1;

    unique case (rx_state_q)
      RxIdle: if (rx_fall) begin
        rx_state_d = RxStart;
        rx_div_d   = cfg_div;
        rx_cnt_d   = cfg_div >> 1;
        rx_nbits_d = cfg_nb;
        rx_par_d   = cfg_par;
        rx_shift_d = '0;
        rx_bit_d   = 4'd0;
      end
      RxStart: if (rx_expire) begin
        rx_state_d = rx_s2_q ? RxIdle : RxData;
        rx_cnt_d   = rx_div_q;
      end
      RxData: if (rx_expire) begin
        rx_cnt_d = rx_div_q;
        for (int i = 0; i < DATA_BITS; i++) begin
          if (4'(i) == rx_bit_q) rx_shift_d[i] = rx_s2_q;
        end
        if (rx_bit_q == rx_nbits_q - 4'd1) begin
          rx_state_d = (rx_par_q != PAR_NONE) ? RxParity : RxStop;
        end else begin
          rx_bit_d = rx_bit_q + 4'd1;
        end
      end
      RxParity: if (rx_expire) begin
        rx_cnt_d   = rx_div_q;
        rx_state_d = RxStop;
        set_parity = data_parity(rx_shift_q, rx_nbits_q) ^ rx_s2_q ^ (rx_par_q == PAR_ODD);
      end
      RxStop: if (rx_expire) begin
        rx_push     = 1'b1;
        set_overrun = rx_full & ~rx_ready;
        if (rx_s2_q) begin
          rx_state_d = RxIdle;
        end else begin
          set_frame  = 1'b1;
          rx_state_d = RxWaitHigh;
        end
      end
      RxWaitHigh: if (rx_s2_q) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_s3_q       <= 1'b1;
      rx_state_q    <= RxIdle;
      rx_cnt_q      <= '0;
      rx_div_q      <= '0;
      rx_shift_q    <= '0;
      rx_nbits_q    <= '0;
      rx_bit_q      <= '0;
      rx_par_q      <= PAR_NONE;
      err_frame_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      rx_s1_q       <= uart_rx;
      rx_s2_q       <= rx_s1_q;
      rx_s3_q       <= rx_s2_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_div_q      <= rx_div_d;
      rx_shift_q    <= rx_shift_d;
      rx_nbits_q    <= rx_nbits_d;
      rx_bit_q      <= rx_bit_d;
      rx_par_q      <= rx_par_d;
      // A new error in the same cycle as a clear stays visible.
      err_frame_q   <= set_frame   | (err_frame_q   & ~err_clr);
      err_parity_q  <= set_parity  | (err_parity_q  & ~err_clr);
      err_overrun_q <= set_overrun | (err_overrun_q & ~err_clr);
    end
  end

  assign rx_valid    = ~rx_empty;
  assign err_frame   = err_frame_q;
  assign err_parity  = err_parity_q;
  assign err_overrun = err_overrun_q;

endmodule
